// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, single-outstanding imem requests, output slot plus hold buffer.
// Build option FETCH_MISALIGN_EN: misaligned redirect targets trap instead of being truncated.
//
// state   | meaning
// RESET   | reset applied, no request yet
// FETCH   | request at pc in flight (or being issued)
// HOLD    | fetched word parked in hold buffer, decode stalled, no request
// KILL    | redirected while a request was in flight; drain and discard its data
// TRAP    | misaligned redirect target, idle until the next redirect
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_branch_en,
  input  logic [31:0] i_branch_tgt,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_dat,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_misaligned
);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_HOLD,
    S_KILL
`ifdef FETCH_MISALIGN_EN
    , S_TRAP
`endif
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        hold_valid;
  logic [31:0] hold_inst;
  logic [31:0] hold_pc;
  logic        slot_free;
  logic        slot_taken;
  logic [31:0] tgt_pc;

  assign slot_free  = !o_valid || !i_stall;
  assign slot_taken = o_valid && !i_stall;

`ifdef FETCH_MISALIGN_EN
  logic tgt_misal;
  logic misal_q;

  assign tgt_misal    = |i_branch_tgt[1:0];
  assign tgt_pc       = tgt_misal ? i_branch_tgt : (i_branch_tgt & ~32'h3);
  assign o_misaligned = misal_q;
`else
  assign tgt_pc       = i_branch_tgt & ~32'h3;
  assign o_misaligned = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= S_RESET;
      pc          <= RESET_VECTOR;
      o_imem_req  <= 1'b0;
      o_imem_addr <= RESET_VECTOR;
      o_valid     <= 1'b0;
      o_inst      <= NOP_INST;
      o_pc        <= '0;
      hold_valid  <= 1'b0;
      hold_inst   <= NOP_INST;
      hold_pc     <= '0;
`ifdef FETCH_MISALIGN_EN
      misal_q     <= 1'b0;
`endif
    end else begin
      // Decode took the slot; later assignments refill it if new data lands.
      if (slot_taken) begin
        o_valid <= 1'b0;
        o_inst  <= NOP_INST;
      end

      if (i_branch_en) begin
        o_valid    <= 1'b0;
        o_inst     <= NOP_INST;
        hold_valid <= 1'b0;
        pc         <= tgt_pc;
`ifdef FETCH_MISALIGN_EN
        misal_q    <= tgt_misal;
`endif
        // An unacked request must complete on its original address.
        if (o_imem_req && !i_imem_ack) begin
          state <= S_KILL;
        end
`ifdef FETCH_MISALIGN_EN
        else if (tgt_misal) begin
          state      <= S_TRAP;
          o_imem_req <= 1'b0;
        end
`endif
        else begin
          state       <= S_FETCH;
          o_imem_req  <= 1'b1;
          o_imem_addr <= tgt_pc;
        end
      end else begin
        case (state)
          S_RESET: begin
            state       <= S_FETCH;
            o_imem_req  <= 1'b1;
            o_imem_addr <= pc;
          end

          S_FETCH: begin
            if (i_imem_ack) begin
              pc <= pc + 32'd4;
              if (slot_free) begin
                o_inst      <= i_imem_dat;
                o_pc        <= o_imem_addr;
                o_valid     <= 1'b1;
                o_imem_addr <= pc + 32'd4;
              end else begin
                hold_inst  <= i_imem_dat;
                hold_pc    <= o_imem_addr;
                hold_valid <= 1'b1;
                o_imem_req <= 1'b0;
                state      <= S_HOLD;
              end
            end
          end

          S_HOLD: begin
            if (!i_stall) begin
              o_inst      <= hold_inst;
              o_pc        <= hold_pc;
              o_valid     <= hold_valid;
              hold_valid  <= 1'b0;
              state       <= S_FETCH;
              o_imem_req  <= 1'b1;
              o_imem_addr <= pc;
            end
          end

          S_KILL: begin
            if (i_imem_ack) begin
`ifdef FETCH_MISALIGN_EN
              if (misal_q) begin
                state      <= S_TRAP;
                o_imem_req <= 1'b0;
              end else begin
                state       <= S_FETCH;
                o_imem_req  <= 1'b1;
                o_imem_addr <= pc;
              end
`else
              state       <= S_FETCH;
              o_imem_req  <= 1'b1;
              o_imem_addr <= pc;
`endif
            end
          end

          default: begin
            o_imem_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with programmable ack latency and a
// scoreboard of delivered (pc, inst) pairs, plus directed cycle-accurate scenarios.
module tb_fetch_unit;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DAT_KEY  = 32'h5A00_0000;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_branch_en;
  logic [31:0] i_branch_tgt;
  logic        i_stall;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_dat;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_misaligned;

  fetch_unit dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_branch_en  (i_branch_en),
    .i_branch_tgt (i_branch_tgt),
    .i_stall      (i_stall),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_dat   (i_imem_dat),
    .o_valid      (o_valid),
    .o_inst       (o_inst),
    .o_pc         (o_pc),
    .o_misaligned (o_misaligned)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb_q[$];
  bit          kill_pending = 1'b0;
  bit          prev_pending = 1'b0;
  logic [31:0] prev_addr = '0;
  int          wait_cnt = 0;
  int          lat = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive memory response, update scoreboard, advance past the edge.
  task automatic tick();
    logic        pre_req;
    logic        pre_ack;
    logic        pre_rst;
    logic [63:0] exp_e;
    i_imem_ack = o_imem_req && (wait_cnt >= lat);
    i_imem_dat = o_imem_addr ^ DAT_KEY;
    pre_req = o_imem_req;
    pre_ack = i_imem_ack;
    pre_rst = i_rst_n;
    if (!i_rst_n) begin
      sb_q.delete();
      kill_pending = 1'b0;
      prev_pending = 1'b0;
    end else begin
      if (o_valid && !i_stall) begin
        exp_e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
        check_eq("sb_pc", o_pc, exp_e[63:32]);
        check_eq("sb_inst", o_inst, exp_e[31:0]);
      end
      if (!o_valid) check_eq("nop_idle", o_inst, NOP_INST);
      if (prev_pending) begin
        check_eq("hs_req", 32'(o_imem_req), 32'd1);
        check_eq("hs_addr", o_imem_addr, prev_addr);
      end
      if (o_imem_req) check_eq("addr_align", 32'(o_imem_addr[1:0]), 32'd0);
      if (i_branch_en) begin
        sb_q.delete();
        kill_pending = o_imem_req && !i_imem_ack;
      end else if (o_imem_req && i_imem_ack) begin
        if (kill_pending) kill_pending = 1'b0;
        else sb_q.push_back({o_imem_addr, o_imem_addr ^ DAT_KEY});
      end
      prev_pending = o_imem_req && !i_imem_ack;
      prev_addr    = o_imem_addr;
    end
    @(posedge i_clk);
    #1;
    if (!pre_rst || (pre_req && pre_ack)) wait_cnt = 0;
    else if (pre_req) wait_cnt++;
  endtask

  task automatic do_reset(input int l);
    i_rst_n = 1'b0;
    i_stall = 1'b0;
    i_branch_en = 1'b0;
    i_branch_tgt = '0;
    lat = l;
    tick();
    tick();
    check_eq("rst_req", 32'(o_imem_req), 32'd0);
    check_eq("rst_addr", o_imem_addr, 32'h0);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_inst", o_inst, NOP_INST);
    check_eq("rst_pc", o_pc, 32'h0);
    check_eq("rst_misal", 32'(o_misaligned), 32'd0);
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic branch(input logic [31:0] tgt);
    i_branch_en = 1'b1;
    i_branch_tgt = tgt;
    tick();
    i_branch_en = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (!o_valid && n < max_cyc) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(o_valid), 32'd1);
  endtask

  initial begin
    i_imem_ack = 1'b0;
    i_imem_dat = '0;

    // Zero-wait streaming after reset release.
    do_reset(0);
    check_eq("t1_req", 32'(o_imem_req), 32'd1);
    check_eq("t1_addr", o_imem_addr, 32'h0);
    tick();
    check_eq("t1_valid", 32'(o_valid), 32'd1);
    check_eq("t1_pc0", o_pc, 32'h0);
    tick();
    check_eq("t1_pc4", o_pc, 32'h4);
    tick();
    check_eq("t1_pc8", o_pc, 32'h8);
    tick();
    check_eq("t1_pcc", o_pc, 32'hC);

    // Stall for three cycles while 0x4 sits in the slot.
    do_reset(0);
    tick();
    tick();
    check_eq("t2_pc4", o_pc, 32'h4);
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t2_stall_req", 32'(o_imem_req), 32'd0);
      check_eq("t2_stall_pc", o_pc, 32'h4);
    end
    i_stall = 1'b0;
    tick();
    check_eq("t2_pc8", o_pc, 32'h8);
    tick();
    check_eq("t2_pcc", o_pc, 32'hC);

    // Three-cycle memory, redirect while the first request is in flight.
    do_reset(3);
    check_eq("t3_addr0", o_imem_addr, 32'h0);
    branch(32'h100);
    check_eq("t3_kill_addr", o_imem_addr, 32'h0);
    tick();
    check_eq("t3_kill_addr1", o_imem_addr, 32'h0);
    tick();
    check_eq("t3_kill_addr2", o_imem_addr, 32'h0);
    tick();
    check_eq("t3_no_old_data", 32'(o_valid), 32'd0);
    check_eq("t3_new_req", 32'(o_imem_req), 32'd1);
    check_eq("t3_new_addr", o_imem_addr, 32'h100);
    wait_valid(10, "t3_wait_valid");
    check_eq("t3_pc", o_pc, 32'h100);

    // Redirect in the same cycle as an ack while decode is stalled.
    do_reset(0);
    tick();
    tick();
    i_stall = 1'b1;
    branch(32'h200);
    i_stall = 1'b0;
    check_eq("t4_valid0", 32'(o_valid), 32'd0);
    check_eq("t4_addr", o_imem_addr, 32'h200);
    tick();
    check_eq("t4_valid1", 32'(o_valid), 32'd1);
    check_eq("t4_pc", o_pc, 32'h200);

    // PC wraps past the top of the address space.
    branch(32'hFFFF_FFFC);
    check_eq("t5_addr_top", o_imem_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("t5_pc_top", o_pc, 32'hFFFF_FFFC);
    check_eq("t5_addr_wrap", o_imem_addr, 32'h0);
    tick();
    check_eq("t5_pc_wrap", o_pc, 32'h0);

    // Misaligned redirect target.
    branch(32'h102);
`ifdef FETCH_MISALIGN_EN
    check_eq("t6_misal", 32'(o_misaligned), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("t6_trap_req", 32'(o_imem_req), 32'd0);
      check_eq("t6_trap_valid", 32'(o_valid), 32'd0);
      tick();
    end
    branch(32'h80);
    check_eq("t6_misal_clr", 32'(o_misaligned), 32'd0);
    check_eq("t6_req", 32'(o_imem_req), 32'd1);
    check_eq("t6_addr", o_imem_addr, 32'h80);
    tick();
    check_eq("t6_pc", o_pc, 32'h80);
`else
    check_eq("t6_misal", 32'(o_misaligned), 32'd0);
    check_eq("t6_req", 32'(o_imem_req), 32'd1);
    check_eq("t6_addr", o_imem_addr, 32'h100);
    tick();
    check_eq("t6_pc", o_pc, 32'h100);
`endif

    // Random stalls and redirects, checked by the scoreboard and handshake rules.
    for (int l = 0; l < 3; l++) begin
      do_reset(l);
      for (int c = 0; c < 300; c++) begin
        i_stall = ($urandom_range(0, 3) == 0);
        i_branch_en = ($urandom_range(0, 15) == 0);
        i_branch_tgt = $urandom() & 32'h0000_0FFC;
        tick();
      end
      // Starve memory so everything already fetched must drain out.
      i_stall = 1'b0;
      i_branch_en = 1'b0;
      lat = 1000;
      for (int c = 0; c < 6; c++) tick();
      check_eq("rand_drain_q", 32'(sb_q.size()), 32'd0);
      check_eq("rand_drain_valid", 32'(o_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that owns the program counter and sits upstream of decode/execute.
- Issues single-outstanding requests to instruction memory and presents fetched instruction/PC pairs to decode through a one-entry output slot plus a one-entry hold buffer.
- Consumes the branch unit's taken signal and target, flushing in-flight work and redirecting the PC.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, instruction driven on o_inst while the slot is empty or in reset.

Ports:
i_clk  input  1  clock; all logic on rising edge.
i_rst_n  input  1  reset, synchronous, active-low.
i_branch_en  input  1  taken branch/jump from execute; single-cycle pulse.
i_branch_tgt  input  32  redirect target, valid when i_branch_en=1.
i_stall  input  1  decode cannot accept; the output slot is consumed only when o_valid=1 and i_stall=0.
o_imem_req  output  1  memory request.
o_imem_addr  output  32  request address, word aligned.
i_imem_ack  input  1  request complete; i_imem_dat is valid in the same cycle.
i_imem_dat  input  32  fetched instruction.
o_valid  output  1  o_inst/o_pc hold a live instruction.
o_inst  output  32  instruction to decode.
o_pc  output  32  address of o_inst.
o_misaligned  output  1  misaligned-target flag; see Optional Feature (tied 0 when the feature is off).

Behaviour:
- Reset (i_rst_n=0 at edge):
  - pc=RESET_VECTOR, state=RESET.
  - o_imem_req=0, o_imem_addr=RESET_VECTOR.
  - o_valid=0, o_inst=NOP_INST, o_pc=0, o_misaligned=0.
  - Hold buffer empty.
  - Reset mid-request abandons the request; memory must tolerate the dropped req.
- States: RESET, FETCH, HOLD, KILL, TRAP (TRAP only with the feature).
- RESET -> FETCH on the first edge with i_rst_n=1. FETCH drives o_imem_req=1 and o_imem_addr=pc.
- Handshake:
  - Once raised, o_imem_req and o_imem_addr stay stable until an edge where i_imem_ack=1.
  - Exactly one request is outstanding at a time.
  - Zero-wait memory (ack in the request cycle) yields one instruction per cycle.
- FETCH + ack, slot free (o_valid=0 or i_stall=0):
  - o_inst<=i_imem_dat, o_pc<=o_imem_addr, o_valid<=1, pc<=pc+4.
  - Stay in FETCH; the next request presents the new pc in the following cycle.
- FETCH + ack, slot busy (o_valid=1 and i_stall=1):
  - Data and address go to the hold buffer, pc<=pc+4.
  - Next state HOLD; o_imem_req=0.
- HOLD:
  - When i_stall=0: hold buffer -> output slot (o_valid stays 1), hold cleared, -> FETCH.
  - While i_stall=1: no change.
- Slot consumed with no new data arriving: o_valid<=0, o_inst<=NOP_INST.
- Redirect (i_branch_en=1) has top priority over ack, stall and HOLD:
  - o_valid<=0, hold cleared, pc<=i_branch_tgt with bits [1:0] forced to 00.
  - Request outstanding and not acked this cycle: -> KILL. o_imem_req/o_imem_addr stay on the old request until ack; the returned data is discarded; then -> FETCH at the new pc.
  - Ack in the same cycle as the redirect: data discarded, -> FETCH at the target next cycle.
  - A redirect during KILL updates pc again; the latest target wins.
- Redirect penalty with zero-wait memory:
  - Target request is driven in cycle N+1 after the branch at N.
  - o_valid=1 with o_pc=target at N+2.
- Arithmetic: pc+4 modulo 2^32, so 32'hFFFF_FFFC -> 32'h0000_0000. No carry-out, no trap.
- i_stall during RESET or KILL has no effect. i_stall with o_valid=0 does not block loading the slot.

Optional Feature:
Macro FETCH_MISALIGN_EN.
- Defined: a redirect with i_branch_tgt[1:0]!=00 does the following:
  - Flushes as normal.
  - Loads pc with the unmodified target and sets o_misaligned=1.
  - Enters TRAP once any outstanding request drains through KILL. No requests are issued in TRAP.
  - Only the next i_branch_en clears o_misaligned and leaves TRAP; an aligned target goes to FETCH, a misaligned one stays in TRAP.
- Undefined: target bits [1:0] are silently cleared, o_misaligned is tied 0, and TRAP logic is absent.

Test Plan:
- Reset release, zero-wait memory returning addr as data -> req at 0x0 in cycle 1; o_valid=1, o_pc=0x0 in cycle 2; o_pc=0x4, 0x8, 0xC on consecutive cycles.
- i_stall=1 for 3 cycles while o_pc=0x4 -> 0x8 captured in hold, o_imem_req=0 during the stall; after release o_pc=0x8, then 0xC; no instruction lost or duplicated.
- Memory with 3-cycle ack latency, i_branch_en with target 0x100 in cycle 1 of the request -> old address held until ack, old data never reaches o_valid=1, next request addr=0x100.
- Redirect coinciding with ack and i_stall=1 -> o_valid=0 next cycle, hold empty, o_pc=0x200 two cycles later for target 0x200.
- pc=0xFFFF_FFFC fetched -> next request addr=0x0000_0000.
- FETCH_MISALIGN_EN defined, target 0x102 -> o_misaligned=1, no o_imem_req, until a redirect to 0x80 yields o_misaligned=0 and req at 0x80. Undefined: same target -> fetch at 0x100.
